// File: rtl/res_addr_gen_if.sv
// rtl/res_addr_gen_if.sv - pixel-strobe in / frame-buffer write out bundle for res_addr_gen
interface res_addr_gen_if #(
  parameter int ADDR_W = 17
);
  logic              in_frame_start;
  logic              in_valid;
  logic [1:0]        in_scale;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              err_overflow;
  logic              err_extra;

  modport master (
    output in_frame_start, in_valid, in_scale,
    input  out_valid, out_addr, out_last, err_overflow, err_extra
  );

  modport slave (
    input  in_frame_start, in_valid, in_scale,
    output out_valid, out_addr, out_last, err_overflow, err_extra
  );
endinterface

// File: rtl/res_addr_gen.sv
// rtl/res_addr_gen.sv - decimating frame-buffer write-address generator
// Row base is accumulated per kept row so no multiplier is needed; two-stage output pipeline.
module res_addr_gen #(
  parameter int SRC_W    = 640,
  parameter int SRC_H    = 480,
  parameter int FB_DEPTH = 76800,
  parameter int ADDR_W   = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  res_addr_gen_if.slave bus
);
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int RW = ADDR_W + 2;
  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_END  = YW'(SRC_H);
  localparam logic [RW-1:0] DEPTH  = RW'(FB_DEPTH);

  logic [1:0]        s_q, s_d;
  logic [XW-1:0]     src_x_q, src_x_d, dst_x_q, dst_x_d;
  logic [YW-1:0]     src_y_q, src_y_d;
  logic [RW-1:0]     row_base_q, row_base_d;

  logic              s1_keep_q, s1_keep_d;
  logic [XW-1:0]     s1_dst_x_q, s1_dst_x_d;
  logic [RW-1:0]     s1_row_base_q, s1_row_base_d;
  logic              s1_last_q, s1_last_d;
  logic              s1_extra_q, s1_extra_d;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_extra_q, err_extra_d;

  logic [1:0]        s_eff, mask;
  logic [XW-1:0]     x_cur, dx_cur, dst_w;
  logic [YW-1:0]     y_cur, dst_h;
  logic [RW-1:0]     rb_cur, sum;
  logic              active, keep, over;

  always_comb begin
    s_eff  = s_q;
    x_cur  = src_x_q;
    y_cur  = src_y_q;
    dx_cur = dst_x_q;
    rb_cur = row_base_q;
    // A frame start restarts the counters in the same cycle, so a coincident pixel is (0,0)
    if (bus.in_frame_start) begin
      s_eff  = (bus.in_scale == 2'd3) ? 2'd2 : bus.in_scale;
      x_cur  = '0;
      y_cur  = '0;
      dx_cur = '0;
      rb_cur = '0;
    end

    case (s_eff)
      2'd0: begin
        mask  = 2'b00;
        dst_w = XW'(SRC_W);
        dst_h = YW'(SRC_H);
      end
      2'd1: begin
        mask  = 2'b01;
        dst_w = XW'(SRC_W / 2);
        dst_h = YW'(SRC_H / 2);
      end
      default: begin
        mask  = 2'b11;
        dst_w = XW'(SRC_W / 4);
        dst_h = YW'(SRC_H / 4);
      end
    endcase

    active = bus.in_valid && (y_cur != Y_END);
    keep   = active && (((x_cur[1:0] | y_cur[1:0]) & mask) == 2'b00);

    s_d        = s_eff;
    src_x_d    = x_cur;
    src_y_d    = y_cur;
    dst_x_d    = dx_cur;
    row_base_d = rb_cur;
    if (active) begin
      if (keep) dst_x_d = dx_cur + 1'b1;
      if (x_cur == X_LAST) begin
        src_x_d = '0;
        src_y_d = y_cur + 1'b1;
        if ((y_cur[1:0] & mask) == 2'b00) begin
          row_base_d = rb_cur + RW'(dst_w);
          dst_x_d    = '0;
        end
      end else begin
        src_x_d = x_cur + 1'b1;
      end
    end

    s1_keep_d     = keep;
    s1_dst_x_d    = dx_cur;
    s1_row_base_d = rb_cur;
    s1_last_d     = keep && (dx_cur == dst_w - 1'b1) && ((y_cur >> s_eff) == dst_h - 1'b1);
    s1_extra_d    = bus.in_valid && !active;

    sum            = s1_row_base_q + RW'(s1_dst_x_q);
    over           = s1_keep_q && (sum >= DEPTH);
    out_valid_d    = s1_keep_q && !over;
    out_addr_d     = out_valid_d ? sum[ADDR_W-1:0] : out_addr_q;
    out_last_d     = out_valid_d && s1_last_q;
    // Clearing on frame start wins over an old-frame error landing on the same edge
    err_overflow_d = bus.in_frame_start ? 1'b0 : (err_overflow_q | over);
    err_extra_d    = bus.in_frame_start ? 1'b0 : (err_extra_q | s1_extra_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q            <= '0;
      src_x_q        <= '0;
      src_y_q        <= '0;
      dst_x_q        <= '0;
      row_base_q     <= '0;
      s1_keep_q      <= 1'b0;
      s1_dst_x_q     <= '0;
      s1_row_base_q  <= '0;
      s1_last_q      <= 1'b0;
      s1_extra_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_last_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_extra_q    <= 1'b0;
    end else begin
      s_q            <= s_d;
      src_x_q        <= src_x_d;
      src_y_q        <= src_y_d;
      dst_x_q        <= dst_x_d;
      row_base_q     <= row_base_d;
      s1_keep_q      <= s1_keep_d;
      s1_dst_x_q     <= s1_dst_x_d;
      s1_row_base_q  <= s1_row_base_d;
      s1_last_q      <= s1_last_d;
      s1_extra_q     <= s1_extra_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_last_q     <= out_last_d;
      err_overflow_q <= err_overflow_d;
      err_extra_q    <= err_extra_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_last     = out_last_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_extra    = err_extra_q;
endmodule

// File: doc/res_addr_gen.md
# res_addr_gen

Streaming frame-buffer write-address generator for the camera capture path. It counts incoming pixel strobes against a parametrised source resolution and decimates by 1, 2 or 4 in both dimensions, with the scale selectable per frame. It produces a pipelined write-enable/address pair for the frame buffer, using incremental row-base accumulation instead of a multiplier. It sits between the capture/demosaic output and the frame-buffer BRAM write port.

## Interface
- SRC_W, 640, source pixels per row
- SRC_H, 480, source rows per frame
- FB_DEPTH, 76800, frame-buffer depth in words
- ADDR_W, 17, address width; must satisfy 2^ADDR_W >= FB_DEPTH
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- in_frame_start  in  1  one-cycle pulse; first pixel of the new frame may coincide
- in_valid  in  1  one source pixel this cycle
- in_scale  in  2  0 = 1:1, 1 = 1/2, 2 = 1/4, 3 = treated as 2; sampled only on in_frame_start
- out_valid  out  1  frame-buffer write enable
- out_addr  out  ADDR_W  write address
- out_last  out  1  with out_valid: last destination pixel of the frame
- err_overflow  out  1  sticky: a kept pixel's address was >= FB_DEPTH
- err_extra  out  1  sticky: in_valid arrived after SRC_W*SRC_H pixels

## Operation
- Internal state:
  - latched scale s (2 bits)
  - src_x, in [0, SRC_W-1]
  - src_y, in [0, SRC_H]
  - dst_x
  - row_base, ADDR_W+2 bits, no wrap
  - dst_w = SRC_W >> s
  - dst_h = SRC_H >> s
- On in_frame_start:
  - latch s.
  - Clear src_x, src_y, dst_x and row_base.
  - Clear err_overflow and err_extra.
  - If in_valid is also high, that pixel is processed as (0,0) under the new s.
- Each in_valid with src_y < SRC_H:
  - Pixel is kept iff the low s bits of src_x and of src_y are all zero.
  - Kept pixel: address = row_base + dst_x.
    - If address >= FB_DEPTH: write suppressed and err_overflow set.
    - Otherwise a write is issued.
  - Kept pixel: dst_x increments.
  - src_x increments. At SRC_W-1 it wraps to 0 and src_y increments.
  - On that wrap, if the finished row was a kept row (low s bits of src_y zero): row_base += dst_w and dst_x is cleared.
- in_valid with src_y == SRC_H is ignored and sets err_extra.
- Frame ended: src_y reaches SRC_H; the block holds until the next in_frame_start.
- out_last asserts with the write for dst pixel (dst_w-1, dst_h-1).
- An in_scale change without in_frame_start has no effect.
- Before the first in_frame_start after reset:
  - s = 0.
  - Counters start at 0, so pixels are processed as a 1:1 frame.

## Timing
- Two-stage pipeline.
  - Stage 1 registers keep, dst_x, row_base and last.
  - Stage 2 registers the addition and the bounds compare.
- out_valid/out_addr/out_last appear exactly 2 cycles after the qualifying in_valid edge.
- One output per input cycle maximum; back-to-back in_valid gives back-to-back writes. There is no backpressure.
- err flags update on the same cycle out_valid would have asserted.
- Flags are cleared the cycle after in_frame_start is sampled.
- Pixels of the old frame still in the pipeline complete normally when in_frame_start arrives.
- Reset values (rst_n low on an edge):
  - out_valid=0, out_addr=0, out_last=0, err_overflow=0, err_extra=0.
  - Pipeline flushed: in-flight writes are dropped.
  - s=0, all counters 0.

## Test plan
- Scale 1, full 640x480 frame, continuous in_valid:
  - exactly 76800 writes, addresses 0..76799 in order.
  - first write 2 cycles after first in_valid.
  - out_last only on address 76799.
  - no error flags.
- Scale 2, full frame:
  - 19200 writes.
  - source pixel (4,4) maps to address 161; source (636,476) maps to 19199 with out_last.
  - pixels with odd x or y produce no write.
- Scale 0, full frame, FB_DEPTH 76800:
  - writes 0..76799 cover rows 0..119.
  - row 120 suppresses writes and sets err_overflow.
  - err_overflow clears after the next in_frame_start.
- Gapped in_valid (random 50% duty), scale 1:
  - address sequence identical to the continuous case.
  - each write lags its in_valid by 2 cycles.
- 307201st in_valid without frame start: err_extra=1, no write.
- Mid-frame events:
  - in_scale changes from 1 to 2 mid-frame: no effect until the next frame start.
  - in_frame_start coincident with in_valid: that pixel gets address 0.
  - rst_n low mid-frame: outputs 0 next cycle and the in-flight write is dropped.
